pll_lock_supervisor: RTL

- Controls the reset side of the PLL: drives the PLL's reset input, watches its locked output, and releases system reset to the outclk_0 domain only after lock has been stable.
- Runs on the free-running reference clock, so it keeps working while the PLL output is stopped.
- Retries acquisition on timeout and re-runs the sequence on loss of lock.
- Latches a fault after repeated failed acquisitions.

---
 rtl/pll_sup_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: state encoding and counter width helper.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal; clears to 0 on synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer on refclk: pulses pll_rst, waits for stable lock, releases sys_rst, retries, latches fault.
// Define PLL_LOCK_GLITCH_FILTER_EN to ignore lock drops in RUN shorter than GLITCH_CYCLES.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 8,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clear_fault,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             lock_ok,
  output logic             fault,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [2:0]       state
);

  localparam int RST_W   = cnt_w(RST_CYCLES);
  localparam int LT_W    = cnt_w(LOCK_TIMEOUT);
  localparam int STAB_W  = cnt_w(STABLE_CYCLES);
  localparam int RETRY_W = cnt_w(MAX_RETRIES + 1);

  if (LOCK_TIMEOUT <= STABLE_CYCLES + 4) begin : g_bad_timeout
    $error("LOCK_TIMEOUT must exceed STABLE_CYCLES+4");
  end
  if (RST_CYCLES < 1 || STABLE_CYCLES < 1 || MAX_RETRIES < 1 || GLITCH_CYCLES < 1) begin : g_bad_param
    $error("RST_CYCLES, STABLE_CYCLES, MAX_RETRIES and GLITCH_CYCLES must be >= 1");
  end

  pll_state_e         state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [LT_W-1:0]    lock_timer_q, lock_timer_d;
  logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d, retry_inc;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               lock_ok_q, lock_ok_d;
  logic               fault_q, fault_d;
  logic               locked_s;
  logic               timeout;
  logic               loss;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int DROP_W = cnt_w(GLITCH_CYCLES);
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
`endif

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (locked_s)
  );

  assign timeout   = (lock_timer_q == LT_W'(LOCK_TIMEOUT - 1));
  assign retry_inc = retry_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = '0;
    lock_timer_d = lock_timer_q;
    stab_cnt_d   = stab_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    loss         = 1'b0;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    drop_cnt_d   = '0;
`endif
    case (state_q)
      PLL_RST: begin
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
          state_d      = WAIT_LOCK;
          lock_timer_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      WAIT_LOCK, STABLE: begin
        lock_timer_d = lock_timer_q + 1'b1;
        // The timer spans both states so lock chatter cannot stretch acquisition.
        if (timeout) begin
          lock_timer_d = '0;
          retry_cnt_d  = retry_inc;
          state_d      = (retry_inc == RETRY_W'(MAX_RETRIES)) ? FAULT : PLL_RST;
        end else if (state_q == WAIT_LOCK) begin
          if (locked_s) begin
            state_d    = STABLE;
            stab_cnt_d = '0;
          end
        end else if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (stab_cnt_q == STAB_W'(STABLE_CYCLES - 1)) begin
          state_d     = RUN;
          retry_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      RUN: begin
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        if (!locked_s) begin
          if (drop_cnt_q == DROP_W'(GLITCH_CYCLES - 1)) loss = 1'b1;
          else drop_cnt_d = drop_cnt_q + 1'b1;
        end
`else
        loss = !locked_s;
`endif
        if (loss) begin
          state_d = PLL_RST;
          if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d     = PLL_RST;
          retry_cnt_d = '0;
        end
      end
      default: state_d = PLL_RST;
    endcase

    pll_rst_d = (state_d == PLL_RST) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    lock_ok_d = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= PLL_RST;
      rst_cnt_q    <= '0;
      lock_timer_q <= '0;
      stab_cnt_q   <= '0;
      retry_cnt_q  <= '0;
      loss_cnt_q   <= '0;
      pll_rst_q    <= 1'b1;
      sys_rst_q    <= 1'b1;
      lock_ok_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      lock_timer_q <= lock_timer_d;
      stab_cnt_q   <= stab_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      pll_rst_q    <= pll_rst_d;
      sys_rst_q    <= sys_rst_d;
      lock_ok_q    <= lock_ok_d;
      fault_q      <= fault_d;
    end
  end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  always_ff @(posedge refclk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end
`endif

  assign pll_rst  = pll_rst_q;
  assign sys_rst  = sys_rst_q;
  assign lock_ok  = lock_ok_q;
  assign fault    = fault_q;
  assign loss_cnt = loss_cnt_q;
  assign state    = state_q;

endmodule
